// File: rtl/eq_share_sched.sv
// Round-robin scheduler sharing one external 1-bit equality cell among NREQ requesters.
// The granted word pair is frozen and streamed LSB first; the first mismatch ends the compare.
module eq_share_sched #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned IDW  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] a_in,
   input  logic [NREQ*WIDTH-1:0] b_in,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  done,
   output logic [IDW-1:0]        done_id,
   output logic                  eq_out,
   output logic                  cmp_a,
   output logic                  cmp_b,
   input  logic                  cmp_eq
);

   localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

   state_e               state_q, state_d;
   logic [IDW-1:0]       last_q, last_d;
   logic [IDW-1:0]       cur_id_q, cur_id_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [WIDTH-1:0]     opa_q, opa_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic [NREQ-1:0]      gnt_q, gnt_d;
   logic                 eq_q, eq_d;
   logic [IDW-1:0]       done_id_q, done_id_d;

   logic [WIDTH-1:0]     a_word [NREQ];
   logic [WIDTH-1:0]     b_word [NREQ];
   logic                 win_valid;
   logic [IDW-1:0]       win_id;

   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         a_word[i] = a_in[i*WIDTH +: WIDTH];
         b_word[i] = b_in[i*WIDTH +: WIDTH];
      end
   end

   // Search starts just after the last winner and wraps, so every requester waits at most NREQ-1.
   always_comb begin
      int unsigned    s;
      logic [IDW-1:0] c;
      win_valid = 1'b0;
      win_id    = '0;
      s         = 0;
      c         = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         s = (32'(last_q) + k) % NREQ;
         c = IDW'(s);
         if (!win_valid && req[c]) begin
            win_valid = 1'b1;
            win_id    = c;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      cur_id_d  = cur_id_q;
      idx_d     = idx_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      gnt_d     = '0;
      eq_d      = eq_q;
      done_id_d = done_id_q;
      unique case (state_q)
         StIdle: begin
            if (win_valid) begin
               opa_d         = a_word[win_id];
               opb_d         = b_word[win_id];
               last_d        = win_id;
               cur_id_d      = win_id;
               idx_d         = '0;
               gnt_d[win_id] = 1'b1;
               state_d       = StCmp;
            end
         end
         StCmp: begin
            if (!cmp_eq) begin
               eq_d      = 1'b0;
               done_id_d = cur_id_q;
               state_d   = StDone;
            end else if (idx_q == IW'(WIDTH - 1)) begin
               eq_d      = 1'b1;
               done_id_d = cur_id_q;
               state_d   = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: begin
            idx_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         last_q    <= IDW'(NREQ - 1);
         cur_id_q  <= '0;
         idx_q     <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         gnt_q     <= '0;
         eq_q      <= 1'b0;
         done_id_q <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cur_id_q  <= cur_id_d;
         idx_q     <= idx_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         gnt_q     <= gnt_d;
         eq_q      <= eq_d;
         done_id_q <= done_id_d;
      end
   end

   assign gnt     = gnt_q;
   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StDone);
   assign done_id = done_id_q;
   assign eq_out  = eq_q;
   assign cmp_a   = (state_q == StCmp) & opa_q[idx_q];
   assign cmp_b   = (state_q == StCmp) & opb_q[idx_q];

endmodule
